// File: rtl/regfile_pkg.sv
// Shared definitions for the register file / pending-write scoreboard slice.
//   XLEN_DEF, NREGS_DEF, NRD_DEF, CNTW_DEF : default parameter values
//   X0_ADDR                                : architectural zero register index
//   clog2()                                : constant address-width helper
//   `RF_SLICE(k, w)                        : part-select for packed port k of width w
// Optional feature macro used by the top: REGFILE_BYPASS_EN.

`ifndef RF_SLICE
`define RF_SLICE(k, w) (k)*(w) +: (w)
`endif

package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int CNTW_DEF  = 2;
  localparam int X0_ADDR   = 0;

  // Smallest w with 2**w >= value (value >= 2 in this design).
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << w) < value) begin
        w = w + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_pending_ctr.sv
// Array of NREGS saturating up/down pending-producer counters.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous clear of every counter, wins over inc/dec
//   inc_en/addr  : accepted issue to a register (caller excludes x0)
//   dec_en/addr  : writeback to a register (caller excludes x0)
//   cnt          : registered counter values, one CNTW slice per register

module regfile_pending_ctr
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int CNTW  = CNTW_DEF,
  parameter int AW    = clog2(NREGS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        inc_en,
  input  logic [AW-1:0]               inc_addr,
  input  logic                        dec_en,
  input  logic [AW-1:0]               dec_addr,
  output logic [NREGS-1:0][CNTW-1:0]  cnt
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [NREGS-1:0][CNTW-1:0] cnt_next_s;

  // Next-state per counter: an issue and a retire on the same register cancel out.
  always_comb begin
    cnt_next_s = cnt;
    for (int r = 0; r < NREGS; r++) begin
      if (flush) begin
        cnt_next_s[r] = '0;
      end else if (inc_en && (inc_addr == AW'(r)) && !(dec_en && (dec_addr == AW'(r)))) begin
        if (cnt[r] != CNT_MAX) begin
          cnt_next_s[r] = cnt[r] + CNTW'(1);
        end else begin
          cnt_next_s[r] = cnt[r];
        end
      end else if (dec_en && (dec_addr == AW'(r)) && !(inc_en && (inc_addr == AW'(r)))) begin
        // Retiring a register with nothing pending leaves it at zero.
        if (cnt[r] != '0) begin
          cnt_next_s[r] = cnt[r] - CNTW'(1);
        end else begin
          cnt_next_s[r] = cnt[r];
        end
      end else begin
        cnt_next_s[r] = cnt[r];
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next_s;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with per-register pending-write scoreboard.
//   clk, reset_n      : clock, asynchronous active-low reset
//   rd_addr/rd_data   : NRD packed combinational read ports (x0 reads zero)
//   rd_busy           : per-port "register has in-flight producers" flag
//   wr_en/addr/data   : single writeback port (writes to x0 discarded)
//   iss_valid/addr    : decode issuing an instruction that will write iss_addr
//   iss_ready         : issue accepted this cycle
//   flush             : clear all pending counters at the next edge
// Optional macro REGFILE_BYPASS_EN: a same-cycle writeback is forwarded to
// matching read ports and counted as already retired for rd_busy.

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF,
  parameter int CNTW  = CNTW_DEF,
  localparam int AW   = clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_ready,
  input  logic                 flush
);

  localparam logic [AW-1:0]   ZERO_ADDR = AW'(X0_ADDR);
  localparam logic [CNTW-1:0] CNT_MAX   = '1;

  logic [XLEN-1:0]            regs_r [NREGS];
  logic [NREGS-1:0][CNTW-1:0] cnt_s;
  logic                       wr_hit_s;
  logic                       iss_nz_s;

  assign wr_hit_s = wr_en && (wr_addr != ZERO_ADDR);
  assign iss_nz_s = (iss_addr != ZERO_ADDR);

  // Issue is refused only when the target counter is full and not draining this cycle.
  always_comb begin
    if (!iss_nz_s) begin
      iss_ready = 1'b1;
    end else if ((cnt_s[iss_addr] == CNT_MAX) && !(wr_hit_s && (wr_addr == iss_addr))) begin
      iss_ready = 1'b0;
    end else begin
      iss_ready = 1'b1;
    end
  end

  regfile_pending_ctr #(
    .NREGS (NREGS),
    .CNTW  (CNTW),
    .AW    (AW)
  ) u_pending_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .inc_en   (iss_valid && iss_ready && iss_nz_s),
    .inc_addr (iss_addr),
    .dec_en   (wr_hit_s),
    .dec_addr (wr_addr),
    .cnt      (cnt_s)
  );

  // Architectural register storage; x0 is never written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= '0;
      end
    end else if (wr_hit_s) begin
      regs_r[wr_addr] <= wr_data;
    end else begin
      regs_r[wr_addr] <= regs_r[wr_addr];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra_s;
    logic [XLEN-1:0] data_s;
    logic            busy_s;

    assign ra_s = rd_addr[`RF_SLICE(k, AW)];

    // Read mux for port k.
    always_comb begin
      if (ra_s == ZERO_ADDR) begin
        data_s = '0;
        busy_s = 1'b0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_hit_s && (wr_addr == ra_s)) begin
        // Forwarded write counts as retired; a zero count stays not-busy.
        data_s = wr_data;
        busy_s = (cnt_s[ra_s] > CNTW'(1));
`endif
      end else begin
        data_s = regs_r[ra_s];
        busy_s = (cnt_s[ra_s] != '0);
      end
    end

    assign rd_data[`RF_SLICE(k, XLEN)] = data_s;
    assign rd_busy[k]                  = busy_s;
  end

endmodule
